// File: rtl/std_dcache_inv_sweeper_if.sv
// rtl/std_dcache_inv_sweeper_if.sv - arbiter requester port used by the dcache invalidate sweeper
//
// Signals (named from the sweeper's point of view):
//   req_o      per-way SRAM request
//   addr_o     set index plus zero line offset
//   we_o       write enable
//   vld_be_o   per-way valid-bit write enable
//   dirty_be_o per-way dirty-bit write enable
//   gnt_i      arbiter grant
interface std_dcache_inv_sweeper_if #(
  parameter int SET_ASSOC   = 8,
  parameter int INDEX_WIDTH = 12
);
  logic [SET_ASSOC-1:0]   req_o;
  logic [INDEX_WIDTH-1:0] addr_o;
  logic                   we_o;
  logic [SET_ASSOC-1:0]   vld_be_o;
  logic [SET_ASSOC-1:0]   dirty_be_o;
  logic                   gnt_i;

  modport master (
    output req_o, addr_o, we_o, vld_be_o, dirty_be_o,
    input  gnt_i
  );

  modport slave (
    input  req_o, addr_o, we_o, vld_be_o, dirty_be_o,
    output gnt_i
  );
endinterface

// File: rtl/std_dcache_inv_sweeper.sv
// rtl/std_dcache_inv_sweeper.sv - walks every dcache set clearing valid and dirty bits of all ways
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset; a sweep starts on release
//   inv_req_i  invalidate request (pulse or level)
//   busy_o     sweep in progress, used to stall the cache controllers
//   done_o     one-cycle pulse when a sweep completes
//   bus        arbiter requester port (master side)
module std_dcache_inv_sweeper #(
  parameter int SET_ASSOC   = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int BYTE_OFFSET = 4,
  parameter int NUM_WORDS   = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inv_req_i,
  output logic busy_o,
  output logic done_o,
  std_dcache_inv_sweeper_if.master bus
);

  localparam int IW = INDEX_WIDTH - BYTE_OFFSET;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  generate
    if (NUM_WORDS != 2 ** (INDEX_WIDTH - BYTE_OFFSET)) begin : g_bad_geometry
      $fatal(1, "NUM_WORDS must equal 2**(INDEX_WIDTH-BYTE_OFFSET)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic          pend, pend_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= SWEEP;
      idx   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      pend  <= pend_next;
    end
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    pend_next      = pend;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    bus.req_o      = '0;
    bus.addr_o     = '0;
    bus.we_o       = 1'b0;
    bus.vld_be_o   = '0;
    bus.dirty_be_o = '0;

    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (inv_req_i) begin
          state_next = SWEEP;
          idx_next   = '0;
        end
      end

      SWEEP: begin
        bus.req_o      = '1;
        bus.we_o       = 1'b1;
        bus.vld_be_o   = '1;
        bus.dirty_be_o = '1;
        bus.addr_o     = {idx, {BYTE_OFFSET{1'b0}}};
        // Requests during a sweep never restart it; they collapse into one follow-up sweep.
        if (inv_req_i) pend_next = 1'b1;
        if (bus.gnt_i) begin
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            state_next = DONE;
          end else begin
            idx_next = idx + IW'(1);
          end
        end
      end

      DONE: begin
        done_o    = 1'b1;
        pend_next = 1'b0;
        idx_next  = '0;
        // A request arriving in this very cycle still launches the next sweep immediately.
        state_next = (pend || inv_req_i) ? SWEEP : IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // While reset is held the port stays quiet but busy keeps the controllers stalled.
    if (rst_i) begin
      busy_o         = 1'b1;
      done_o         = 1'b0;
      bus.req_o      = '0;
      bus.addr_o     = '0;
      bus.we_o       = 1'b0;
      bus.vld_be_o   = '0;
      bus.dirty_be_o = '0;
    end
  end

endmodule

// File: tb/tb_std_dcache_inv_sweeper.sv
// tb/tb_std_dcache_inv_sweeper.sv - directed self-checking bench for std_dcache_inv_sweeper
module tb_std_dcache_inv_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic inv_req;
  logic busy;
  logic done;
  int   tests = 0;
  int   fails = 0;

  std_dcache_inv_sweeper_if #(.SET_ASSOC(8), .INDEX_WIDTH(8)) bus ();

  std_dcache_inv_sweeper #(
    .SET_ASSOC  (8),
    .INDEX_WIDTH(8),
    .BYTE_OFFSET(4),
    .NUM_WORDS  (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .inv_req_i(inv_req),
    .busy_o   (busy),
    .done_o   (done),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // Checks 16 writes (each held 'period' cycles, granted on the last) and then the done cycle.
  task automatic check_sweep(input int period, input logic [15:0] req_mask,
                             input logic done_req, input string nm);
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        rst       = 1'b0;
        inv_req   = (c == 0) && req_mask[k];
        bus.gnt_i = (c == period - 1);
        #1;
        tests++;
        if (bus.req_o !== 8'hFF || bus.addr_o !== 8'(k * 16)) begin
          fails++;
          $display("FAIL %s req/addr idx %0d cyc %0d: got req=%h addr=%h, want req=ff addr=%h",
                   nm, k, c, bus.req_o, bus.addr_o, 8'(k * 16));
        end
        tests++;
        if ({bus.we_o, bus.vld_be_o, bus.dirty_be_o, busy, done} !== {1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL %s flags idx %0d: got we=%b vld=%h dirty=%h busy=%b done=%b, want 1 ff ff 1 0",
                   nm, k, bus.we_o, bus.vld_be_o, bus.dirty_be_o, busy, done);
        end
      end
    end
    @(negedge clk);
    inv_req   = done_req;
    bus.gnt_i = 1'b1;
    #1;
    tests++;
    if ({done, busy, bus.req_o} !== {1'b1, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL %s done cycle: got done=%b busy=%b req=%h, want done=1 busy=1 req=00",
               nm, done, busy, bus.req_o);
    end
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    inv_req   = 1'b0;
    bus.gnt_i = 1'b1;
    #1;
    tests++;
    if ({busy, done, bus.req_o, bus.addr_o, bus.we_o} !== {1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL %s idle: got busy=%b done=%b req=%h addr=%h we=%b, want all 0",
               nm, busy, done, bus.req_o, bus.addr_o, bus.we_o);
    end
  endtask

  // Pulses inv_req from IDLE; the sweep starts in the following cycle.
  task automatic launch(input string nm);
    @(negedge clk);
    inv_req   = 1'b1;
    bus.gnt_i = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || bus.req_o !== 8'h00) begin
      fails++;
      $display("FAIL %s launch in idle: got busy=%b req=%h, want busy=0 req=00", nm, busy, bus.req_o);
    end
  endtask

  task automatic check_in_reset(input string nm);
    @(negedge clk);
    rst       = 1'b1;
    inv_req   = 1'b0;
    bus.gnt_i = 1'b1;
    #1;
    tests++;
    if ({busy, done, bus.req_o, bus.addr_o, bus.we_o, bus.vld_be_o, bus.dirty_be_o} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL %s in reset: got busy=%b done=%b req=%h addr=%h we=%b vld=%h dirty=%h, want busy=1 rest 0",
               nm, busy, done, bus.req_o, bus.addr_o, bus.we_o, bus.vld_be_o, bus.dirty_be_o);
    end
  endtask

  task automatic test_reset();
    check_in_reset("reset_c1");
    check_in_reset("reset_c2");
  endtask

  task automatic test_post_reset_sweep();
    check_sweep(1, 16'h0000, 1'b0, "post_reset");
    check_idle("post_reset_c18");
    check_idle("post_reset_c19");
  endtask

  task automatic test_idle_request();
    launch("idle_req");
    check_sweep(1, 16'h0000, 1'b0, "idle_req");
    check_idle("idle_req_end");
  endtask

  task automatic test_grant_stall();
    launch("stall");
    check_sweep(3, 16'h0000, 1'b0, "stall");
    check_idle("stall_end");
  endtask

  task automatic test_merged_requests();
    launch("merged");
    check_sweep(1, 16'h0224, 1'b0, "merged_first");
    check_sweep(1, 16'h0000, 1'b0, "merged_second");
    check_idle("merged_end");
  endtask

  task automatic test_done_request();
    launch("done_req");
    check_sweep(1, 16'h0000, 1'b1, "done_req_first");
    check_sweep(1, 16'h0000, 1'b0, "done_req_second");
    check_idle("done_req_end");
  endtask

  task automatic test_mid_reset();
    launch("mid_reset");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      inv_req   = (k == 7);
      bus.gnt_i = 1'b1;
      #1;
      tests++;
      if (bus.req_o !== 8'hFF || bus.addr_o !== 8'(k * 16)) begin
        fails++;
        $display("FAIL mid_reset pre idx %0d: got req=%h addr=%h, want req=ff addr=%h",
                 k, bus.req_o, bus.addr_o, 8'(k * 16));
      end
    end
    check_in_reset("mid_reset_c1");
    check_in_reset("mid_reset_c2");
    check_sweep(1, 16'h0000, 1'b0, "mid_reset_restart");
    check_idle("mid_reset_pend_cleared");
  endtask

  initial begin
    rst       = 1'b1;
    inv_req   = 1'b0;
    bus.gnt_i = 1'b1;
    test_reset();
    test_post_reset_sweep();
    test_idle_request();
    test_grant_stall();
    test_merged_requests();
    test_done_request();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
